// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the inter-stage registers.
//   - stage_state_e : occupancy of a pipeline register (empty, main held, main + skid held)
//   - ctrl_t        : MEM/WB control bits carried alongside the data fields
//   - ex_mem_payload_t : EX/MEM payload at the default widths
//   - payload_width(): flattened payload width for arbitrary field widths
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic [DATA_W_DEF-1:0] registro_2;
        logic [ADDR_W_DEF-1:0] jump_dest_addr;
        logic                  zero_signal;
        logic [REG_W_DEF-1:0]  reg_dest;
        ctrl_t                 ctrl;
    } ex_mem_payload_t;

    // Field order of the flattened vector matches ex_mem_payload_t.
    function automatic int unsigned payload_width(input int unsigned data_w,
                                                  input int unsigned addr_w,
                                                  input int unsigned reg_w);
        return 2 * data_w + addr_w + 1 + reg_w + CTRL_W;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised payload register with synchronous clear and load enable.
//   clk_i  : rising-edge clock
//   clr_i  : synchronous clear to zero, wins over en_i
//   en_i   : load d_i at the next edge
//   d_i    : next payload
//   q_o    : held payload
module pipe_payload_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush-to-bubble and a
// saturating stall counter.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     : EX-side handshake
//   out_valid / out_ready   : MEM-side handshake
//   flush                   : drop every held entry at the next edge
//   *_in / *_out            : ALU result, store data, branch target, zero flag,
//                             destination register and MEM/WB control bits
//   stall_count             : saturating count of cycles with out_valid & !out_ready
// Build option EX_MEM_STAGE_SKID_EN: adds a second (skid) entry so in_ready is a
// flop with no path from out_ready. Without it the stage holds one entry and
// in_ready passes out_ready through combinationally.
module ex_mem_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] registro_2_in,
    input  logic [ADDR_W-1:0] jump_dest_addr_in,
    input  logic              zero_signal_in,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] registro_2_out,
    output logic [ADDR_W-1:0] jump_dest_addr_out,
    output logic              zero_signal_out,
    output logic [REG_W-1:0]  reg_dest_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic              Branch_out,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int unsigned PayloadW = payload_width(DATA_W, ADDR_W, REG_W);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t               in_ctrl, main_ctrl, out_ctrl;
    logic [PayloadW-1:0] in_payload, main_payload, main_d;
    logic                main_en;
    logic                in_xfer, out_xfer;
    stage_state_e        state_q, state_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    assign in_ctrl = '{
        mem_to_reg: MemToReg_in,
        reg_write:  RegWrite_in,
        mem_read:   MemRead_in,
        mem_write:  MemWrite_in,
        branch:     Branch_in
    };

    assign in_payload = {result_in, registro_2_in, jump_dest_addr_in, zero_signal_in,
                         reg_dest_in, in_ctrl};

    assign {result_out, registro_2_out, jump_dest_addr_out, zero_signal_out, reg_dest_out,
            main_ctrl} = main_payload;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef EX_MEM_STAGE_SKID_EN
    logic                skid_en;
    logic [PayloadW-1:0] skid_payload;
    logic                in_ready_q, in_ready_d;

    // Next-state: flush beats any handshake; a held skid beat refills main.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_payload;
        skid_en = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d = StFull;
                        main_en = 1'b1;
                    end
                end
                StFull: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        state_d = StSkid;
                        skid_en = 1'b1;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StSkid: begin
                    if (out_xfer) begin
                        state_d = StFull;
                        main_en = 1'b1;
                        main_d  = skid_payload;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StSkid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;

    pipe_payload_reg #(
        .Width (PayloadW)
    ) u_skid_reg (
        .clk_i (clock),
        .clr_i (reset),
        .en_i  (skid_en),
        .d_i   (in_payload),
        .q_o   (skid_payload)
    );
`else
    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_payload;
        if (flush) begin
            state_d = StEmpty;
        end else if (in_xfer) begin
            state_d = StFull;
            main_en = 1'b1;
        end else if (out_xfer) begin
            state_d = StEmpty;
        end
    end
`endif

    // Flush only touches state; data fields keep their last value.
    pipe_payload_reg #(
        .Width (PayloadW)
    ) u_main_reg (
        .clk_i (clock),
        .clr_i (reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_payload)
    );

    // Outputs: controls forced to zero while empty so a bubble is a NOP downstream.
    always_comb begin
        out_valid = (state_q != StEmpty);
        out_ctrl  = '0;
        if (out_valid) begin
            out_ctrl = main_ctrl;
        end
    end

    assign MemToReg_out = out_ctrl.mem_to_reg;
    assign RegWrite_out = out_ctrl.reg_write;
    assign MemRead_out  = out_ctrl.mem_read;
    assign MemWrite_out = out_ctrl.mem_write;
    assign Branch_out   = out_ctrl.branch;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

    localparam int CNT_W = 4;
    localparam logic [4:0] C_MTR = 5'b10000;
    localparam logic [4:0] C_RW  = 5'b01000;
    localparam logic [4:0] C_MR  = 5'b00100;
    localparam logic [4:0] C_MW  = 5'b00010;
    localparam logic [4:0] C_BR  = 5'b00001;

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] result_in, registro_2_in, result_out, registro_2_out;
    logic [10:0] jump_dest_addr_in, jump_dest_addr_out;
    logic        zero_signal_in, zero_signal_out;
    logic [4:0]  reg_dest_in, reg_dest_out;
    logic        MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
    logic        MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out;
    logic [CNT_W-1:0] stall_count;
    logic [4:0]  ctrl_out;
    logic [80:0] data_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign ctrl_out = {MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out};
    assign data_out = {result_out, registro_2_out, jump_dest_addr_out, zero_signal_out,
                       reg_dest_out};

    ex_mem_stage_reg #(
        .DATA_W (32),
        .ADDR_W (11),
        .REG_W  (5),
        .CNT_W  (CNT_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .flush              (flush),
        .result_in          (result_in),
        .registro_2_in      (registro_2_in),
        .jump_dest_addr_in  (jump_dest_addr_in),
        .zero_signal_in     (zero_signal_in),
        .reg_dest_in        (reg_dest_in),
        .MemToReg_in        (MemToReg_in),
        .RegWrite_in        (RegWrite_in),
        .MemRead_in         (MemRead_in),
        .MemWrite_in        (MemWrite_in),
        .Branch_in          (Branch_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .result_out         (result_out),
        .registro_2_out     (registro_2_out),
        .jump_dest_addr_out (jump_dest_addr_out),
        .zero_signal_out    (zero_signal_out),
        .reg_dest_out       (reg_dest_out),
        .MemToReg_out       (MemToReg_out),
        .RegWrite_out       (RegWrite_out),
        .MemRead_out        (MemRead_out),
        .MemWrite_out       (MemWrite_out),
        .Branch_out         (Branch_out),
        .stall_count        (stall_count)
    );

    // Expected data fields for a beat whose result is r (other fields derived from r).
    function automatic logic [80:0] exp_data(input logic [31:0] r);
        logic [10:0] j;
        j = r[10:0] ^ 11'h155;
        return {r, ~r, j, r[0], r[4:0]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] c);
        in_valid          = v;
        result_in         = r;
        registro_2_in     = ~r;
        jump_dest_addr_in = r[10:0] ^ 11'h155;
        zero_signal_in    = r[0];
        reg_dest_in       = r[4:0];
        {MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in} = c;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        out_ready = 1'b1;
        flush     = 1'b0;
        reset     = 1'b1;
        drive(1'b1, 32'hAA, C_RW | C_MW);
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0 || ctrl_out !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got valid=%0b ctrl=%0h required valid=0 ctrl=0",
                         i, out_valid, ctrl_out);
            end
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        checks++;
        if (stall_count !== '0 || data_out !== 81'h0) begin
            errors++;
            $display("FAIL reset_values: got stall=%0d data=%0h required 0 0",
                     stall_count, data_out);
        end
    endtask

    task automatic test_streaming;
        logic [31:0] vals [3];
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        do_reset;
        out_ready = 1'b1;
        drive(1'b1, vals[0], C_RW);
        tick;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== exp_data(vals[i]) || ctrl_out !== C_RW) begin
                errors++;
                $display("FAIL stream_beat[%0d]: got v=%0b d=%0h c=%0h required v=1 d=%0h c=%0h",
                         i, out_valid, data_out, ctrl_out, exp_data(vals[i]), C_RW);
            end
            if (i < 2) drive(1'b1, vals[i+1], C_RW);
            else       drive(1'b0, 32'h0, 5'b0);
            tick;
        end
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 5'b0 || result_out !== 32'h33) begin
            errors++;
            $display("FAIL stream_bubble: got v=%0b c=%0h r=%0h required v=0 c=0 r=33",
                     out_valid, ctrl_out, result_out);
        end
        checks++;
        if (stall_count !== '0) begin
            errors++;
            $display("FAIL stream_stall: got %0d required 0", stall_count);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        out_ready = 1'b1;
        drive(1'b1, 32'h11, C_MR);
        tick;
`ifdef EX_MEM_STAGE_SKID_EN
        out_ready = 1'b0;
        drive(1'b1, 32'h22, C_MTR | C_RW);
        tick;
        drive(1'b0, 32'h0, 5'b0);
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (in_ready !== 1'b0 || result_out !== 32'h11 || stall_count !== CNT_W'(i)) begin
                errors++;
                $display("FAIL skid_hold[%0d]: got rdy=%0b r=%0h st=%0d required 0 11 %0d",
                         i, in_ready, result_out, stall_count, i);
            end
            if (i == 1) tick;
        end
        out_ready = 1'b1;
        tick;
        checks++;
        if (in_ready !== 1'b1 || data_out !== exp_data(32'h22) || ctrl_out !== (C_MTR | C_RW)) begin
            errors++;
            $display("FAIL skid_drain: got rdy=%0b d=%0h c=%0h required 1 %0h %0h",
                     in_ready, data_out, ctrl_out, exp_data(32'h22), C_MTR | C_RW);
        end
`else
        out_ready = 1'b0;
        drive(1'b1, 32'h22, C_MTR | C_RW);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_low: got %0b required 0", in_ready);
        end
        for (int i = 1; i <= 2; i++) begin
            tick;
            checks++;
            if (result_out !== 32'h11 || ctrl_out !== C_MR || stall_count !== CNT_W'(i)) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got r=%0h c=%0h st=%0d required 11 %0h %0d",
                         i, result_out, ctrl_out, stall_count, C_MR, i);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_pass: got %0b required 1", in_ready);
        end
        tick;
        checks++;
        if (data_out !== exp_data(32'h22) || ctrl_out !== (C_MTR | C_RW)) begin
            errors++;
            $display("FAIL bp_next: got d=%0h c=%0h required %0h %0h",
                     data_out, ctrl_out, exp_data(32'h22), C_MTR | C_RW);
        end
        drive(1'b0, 32'h0, 5'b0);
`endif
        tick;
        checks++;
        if (out_valid !== 1'b0 || stall_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL bp_end: got v=%0b st=%0d required 0 2", out_valid, stall_count);
        end
    endtask

    task automatic test_flush;
        do_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h55, C_RW | C_MW);
        tick;
        drive(1'b0, 32'h0, 5'b0);
        checks++;
        if (out_valid !== 1'b1 || ctrl_out !== (C_RW | C_MW)) begin
            errors++;
            $display("FAIL flush_pre: got v=%0b c=%0h required 1 %0h",
                     out_valid, ctrl_out, C_RW | C_MW);
        end
        tick;
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h44, C_RW | C_MW | C_BR);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready: got %0b required 1", in_ready);
        end
        tick;
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 5'b0 || result_out !== 32'h55) begin
            errors++;
            $display("FAIL flush_bubble: got v=%0b c=%0h r=%0h required 0 0 55",
                     out_valid, ctrl_out, result_out);
        end
        checks++;
        if (stall_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL flush_keeps_stall: got %0d required 1", stall_count);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || result_out !== 32'h55) begin
            errors++;
            $display("FAIL flush_no_44: got v=%0b r=%0h required 0 55", out_valid, result_out);
        end
`ifdef EX_MEM_STAGE_SKID_EN
        do_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h11, C_RW);
        tick;
        drive(1'b1, 32'h22, C_RW);
        tick;
        flush = 1'b1;
        drive(1'b0, 32'h0, 5'b0);
        tick;
        flush     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_skid: got v=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || result_out !== 32'h11) begin
            errors++;
            $display("FAIL flush_skid_gone: got v=%0b r=%0h required 0 11", out_valid, result_out);
        end
`endif
    endtask

    task automatic test_saturation;
        logic [CNT_W-1:0] exp;
        do_reset;
        out_ready = 1'b0;
        drive(1'b1, 32'h66, C_MR);
        tick;
        drive(1'b0, 32'h0, 5'b0);
        for (int i = 1; i <= 20; i++) begin
            tick;
            exp = (i > 15) ? CNT_W'(15) : CNT_W'(i);
            checks++;
            if (stall_count !== exp) begin
                errors++;
                $display("FAIL sat[%0d]: got %0d required %0d", i, stall_count, exp);
            end
        end
        checks++;
        if (out_valid !== 1'b1 || result_out !== 32'h66) begin
            errors++;
            $display("FAIL sat_held: got v=%0b r=%0h required 1 66", out_valid, result_out);
        end
    endtask

    task automatic test_reset_mid;
        reset = 1'b1;
        drive(1'b1, 32'h77, C_RW);
        tick;
        reset = 1'b0;
        drive(1'b0, 32'h0, 5'b0);
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || ctrl_out !== 5'b0 || stall_count !== '0 || result_out !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b c=%0h st=%0d r=%0h required 0 0 0 0",
                     out_valid, ctrl_out, stall_count, result_out);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: got v=%0b required 0", out_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 5'b0);
        test_reset;
        test_streaming;
        test_backpressure;
        test_flush;
        test_saturation;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
